// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory arbiter: store-type codes,
// owner state encoding and the default legal address limit.
package dm_pkg;

  localparam logic [2:0] ST_WORD = 3'd0;
  localparam logic [2:0] ST_HALF = 3'd1;
  localparam logic [2:0] ST_BYTE = 3'd2;

  // First illegal byte address: 2048 words of data memory.
  localparam logic [31:0] ADDR_LIMIT_DEFAULT = 32'h0000_2000;

  // Winner of the previous cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    DMA  = 2'd2
  } owner_e;

endpackage

// File: rtl/dm_arbiter_if.sv
// Bundle of the CPU, DMA and data-memory signals around the arbiter.
// slave: the arbiter itself; master: requesters plus the memory.
interface dm_arbiter_if;
  import dm_pkg::*;

  logic        cpu_req;
  logic        cpu_we;
  logic [2:0]  cpu_type;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  logic        dma_req;
  logic        dma_we;
  logic [2:0]  dma_type;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic [31:0] dma_rdata;
  logic        dma_rvalid;

  logic        err;
  owner_e      owner;

  logic        MemWrite;
  logic [2:0]  StoreType;
  logic [31:0] Addr;
  logic [31:0] DataW;
  logic [31:0] DataR;

  modport slave (
    input  cpu_req, cpu_we, cpu_type, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_type, dma_addr, dma_wdata,
    input  DataR,
    output cpu_rdata, cpu_stall, dma_gnt, dma_rdata, dma_rvalid,
    output err, owner, MemWrite, StoreType, Addr, DataW
  );

  modport master (
    output cpu_req, cpu_we, cpu_type, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_type, dma_addr, dma_wdata,
    output DataR,
    input  cpu_rdata, cpu_stall, dma_gnt, dma_rdata, dma_rvalid,
    input  err, owner, MemWrite, StoreType, Addr, DataW
  );

endinterface

// File: rtl/dm_access_check.sv
// Combinational legality check for one requester: address below the
// limit, a known store type, and natural alignment for that type.
module dm_access_check
  import dm_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEFAULT
) (
  input  logic [31:0] addr,
  input  logic [2:0]  stype,
  output logic        legal
);

  logic aligned;

  // Alignment requirement depends on access size; unknown types never pass.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    aligned = 1'b0;
    case (stype)
      ST_WORD: aligned = (addr[1:0] == 2'b00);
      ST_HALF: aligned = ~addr[0];
      ST_BYTE: aligned = 1'b1;
      default: aligned = 1'b0;
    endcase
  end

  assign legal = (addr < ADDR_LIMIT) && aligned;

endmodule

// File: rtl/dm_arbiter.sv
// Single-cycle arbiter sharing the data memory port between the CPU MEM
// stage and a DMA/debug requester. CPU has priority; when the macro
// DM_ARB_FAIR_EN is defined a starvation counter forces a DMA grant after
// STARVE_MAX contended cycles won back-to-back by the CPU.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  dm_arbiter_if.slave  bus
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_starve_range
    $error("dm_arbiter: STARVE_MAX must be within 1..15");
  end

  owner_e      owner_q, owner_d;
  logic        cpu_legal, dma_legal;
  logic        cpu_gnt, dma_gnt;
  logic        force_dma;
  logic        err_q, rvalid_q;
  logic [31:0] rdata_q;

  dm_access_check #(.ADDR_LIMIT(ADDR_LIMIT)) u_cpu_check (
    .addr  (bus.cpu_addr),
    .stype (bus.cpu_type),
    .legal (cpu_legal)
  );

  dm_access_check #(.ADDR_LIMIT(ADDR_LIMIT)) u_dma_check (
    .addr  (bus.dma_addr),
    .stype (bus.dma_type),
    .legal (dma_legal)
  );

`ifdef DM_ARB_FAIR_EN
  logic [3:0] starve_cnt;

  assign force_dma = bus.cpu_req & bus.dma_req & (starve_cnt == 4'(STARVE_MAX));

  // Count contended cycles the CPU wins; clear once DMA is let in or stops asking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= 4'd0;
    end else if (!bus.dma_req || force_dma) begin
      starve_cnt <= 4'd0;
    end else if (bus.cpu_req) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  assign force_dma = 1'b0;
`endif

  // Grant decision and next owner; the CPU wins unless DMA is being forced.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    owner_d = IDLE;
    if (bus.cpu_req && !force_dma) begin
      cpu_gnt = 1'b1;
      owner_d = CPU;
    end else if (bus.dma_req) begin
      dma_gnt = 1'b1;
      owner_d = DMA;
    end
  end

  // Memory-side mux: everything from the winner, all zero when idle.
  always_comb begin
    bus.MemWrite  = 1'b0;
    bus.StoreType = 3'd0;
    bus.Addr      = 32'd0;
    bus.DataW     = 32'd0;
    if (cpu_gnt) begin
      bus.MemWrite  = bus.cpu_we & cpu_legal;
      bus.StoreType = bus.cpu_type;
      bus.Addr      = bus.cpu_addr;
      bus.DataW     = bus.cpu_wdata;
    end else if (dma_gnt) begin
      bus.MemWrite  = bus.dma_we & dma_legal;
      bus.StoreType = bus.dma_type;
      bus.Addr      = bus.dma_addr;
      bus.DataW     = bus.dma_wdata;
    end
  end

  // Owner register plus the one-cycle err / DMA read-return pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: rdata_q is a plain data register, so it resets with the rest; no RAM here.
      owner_q  <= IDLE;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      owner_q  <= owner_d;
      err_q    <= (cpu_gnt & ~cpu_legal) | (dma_gnt & ~dma_legal);
      rvalid_q <= dma_gnt & ~bus.dma_we;
      if (dma_gnt && !bus.dma_we) begin
        rdata_q <= dma_legal ? bus.DataR : 32'd0;
      end
    end
  end

  assign bus.cpu_rdata  = cpu_gnt ? bus.DataR : 32'd0;
  assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt;
  assign bus.dma_gnt    = dma_gnt;
  assign bus.dma_rdata  = rdata_q;
  assign bus.dma_rvalid = rvalid_q;
  assign bus.err        = err_q;
  assign bus.owner      = owner_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios plus a randomized
// run compared against a behavioural model of the arbitration rules.
module tb_dm_arbiter;
  import dm_pkg::*;

`ifdef DM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  localparam int STARVE = 4;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  dm_arbiter_if bus ();

  dm_arbiter #(.STARVE_MAX(STARVE), .ADDR_LIMIT(32'h0000_2000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Data memory seen by the DUT, and the bench's own shadow of it.
  logic [31:0] dm_mem  [2048];
  logic [31:0] ref_mem [2048];
  bit          mem_ready;

  function automatic logic [31:0] init_word(int i);
    return (i * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d,
                                        logic [2:0] t, logic [31:0] a);
    logic [31:0] r;
    r = old;
    case (t)
      3'd0: r = d;
      3'd1: if (a[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
      3'd2: r[a[1:0]*8 +: 8] = d[7:0];
      default: r = old;
    endcase
    return r;
  endfunction

  assign bus.DataR = dm_mem[bus.Addr[12:2]];

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 2048; i++) dm_mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (bus.MemWrite) begin
      dm_mem[bus.Addr[12:2]] <= merge(dm_mem[bus.Addr[12:2]], bus.DataW, bus.StoreType, bus.Addr);
    end
  end

  // ---------------- reference model ----------------
  function automatic bit legal(logic [31:0] a, logic [2:0] t);
    if (a >= 32'h2000 || t > 3'd2) return 1'b0;
    if (t == 3'd0) return (a % 4) == 0;
    if (t == 3'd1) return (a % 2) == 0;
    return 1'b1;
  endfunction

  int          m_cnt;
  int          win;           // 0 none, 1 CPU, 2 DMA
  bit          e_dgnt, e_stall, e_mw;
  logic [2:0]  e_type;
  logic [31:0] e_addr, e_dw, e_cpu_rdata;
  bit          exp_err, exp_rvalid;
  logic [31:0] exp_rdata;
  owner_e      exp_owner;

  function automatic void eval_model();
    bit contended, forced;
    contended = bus.cpu_req && bus.dma_req;
    forced    = FAIR && contended && (m_cnt == STARVE);
    if (bus.cpu_req && !forced) win = 1;
    else if (bus.dma_req)       win = 2;
    else                        win = 0;
    e_dgnt = (win == 2);
    e_stall = bus.cpu_req && (win != 1);
    e_mw = 1'b0; e_type = 3'd0; e_addr = 32'd0; e_dw = 32'd0; e_cpu_rdata = 32'd0;
    if (win == 1) begin
      e_mw = bus.cpu_we && legal(bus.cpu_addr, bus.cpu_type);
      e_type = bus.cpu_type; e_addr = bus.cpu_addr; e_dw = bus.cpu_wdata;
      e_cpu_rdata = ref_mem[bus.cpu_addr[12:2]];
    end else if (win == 2) begin
      e_mw = bus.dma_we && legal(bus.dma_addr, bus.dma_type);
      e_type = bus.dma_type; e_addr = bus.dma_addr; e_dw = bus.dma_wdata;
    end
  endfunction

  // Advance one clock: model consumes the current inputs, ends at next negedge.
  task automatic tick();
    bit          n_err, n_rv, creq, dreq;
    logic [31:0] n_rd;
    owner_e      n_owner;
    eval_model();
    n_err = (win == 1 && !legal(bus.cpu_addr, bus.cpu_type)) ||
            (win == 2 && !legal(bus.dma_addr, bus.dma_type));
    n_rv  = (win == 2) && !bus.dma_we;
    n_rd  = legal(bus.dma_addr, bus.dma_type) ? ref_mem[bus.dma_addr[12:2]] : 32'd0;
    n_owner = (win == 1) ? CPU : (win == 2) ? DMA : IDLE;
    creq = bus.cpu_req; dreq = bus.dma_req;
    @(posedge clk);
    if (e_mw) ref_mem[e_addr[12:2]] = merge(ref_mem[e_addr[12:2]], e_dw, e_type, e_addr);
    if (!reset) begin
      exp_err = 1'b0; exp_rvalid = 1'b0; exp_rdata = 32'd0; exp_owner = IDLE; m_cnt = 0;
    end else begin
      exp_err = n_err; exp_rvalid = n_rv; exp_owner = n_owner;
      if (n_rv) exp_rdata = n_rd;
      if (!dreq)                   m_cnt = 0;
      else if (win == 2 && creq)   m_cnt = 0;
      else if (win == 1)           m_cnt = m_cnt + 1;
    end
    @(negedge clk);
  endtask

  task automatic set_cpu(bit req, bit we, logic [2:0] t, logic [31:0] a, logic [31:0] d);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_type = t; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic set_dma(bit req, bit we, logic [2:0] t, logic [31:0] a, logic [31:0] d);
    bus.dma_req = req; bus.dma_we = we; bus.dma_type = t; bus.dma_addr = a; bus.dma_wdata = d;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (bus.dma_rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid got=%b exp=0", bus.dma_rvalid); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    n_cmp++; if (bus.dma_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rdata got=%h exp=0", bus.dma_rdata); end
    n_cmp++; if (bus.owner !== IDLE) begin n_bad++; $display("FAIL reset_owner got=%0d exp=IDLE", bus.owner); end
    n_cmp++; if ({bus.MemWrite, bus.Addr, bus.dma_gnt, bus.cpu_stall} !== 35'd0) begin
      n_bad++; $display("FAIL reset_idle_bus got mw=%b addr=%h gnt=%b stall=%b exp all 0",
                        bus.MemWrite, bus.Addr, bus.dma_gnt, bus.cpu_stall);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cpu_only();
    set_dma(0, 0, 0, 0, 0);
    set_cpu(1, 1, ST_WORD, 32'h10, 32'hDEADBEEF);
    #1;
    n_cmp++; if (bus.MemWrite !== 1'b1) begin n_bad++; $display("FAIL cpu_wr_memwrite got=%b exp=1", bus.MemWrite); end
    n_cmp++; if (bus.Addr !== 32'h10 || bus.DataW !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL cpu_wr_bus got addr=%h data=%h exp addr=10 data=deadbeef", bus.Addr, bus.DataW);
    end
    n_cmp++; if (bus.cpu_stall !== 1'b0) begin n_bad++; $display("FAIL cpu_wr_stall got=%b exp=0", bus.cpu_stall); end
    tick();
    set_cpu(1, 0, ST_WORD, 32'h10, 32'd0);
    #1;
    n_cmp++; if (bus.cpu_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL cpu_rd_data got=%h exp=deadbeef", bus.cpu_rdata); end
    n_cmp++; if (bus.cpu_stall !== 1'b0 || bus.MemWrite !== 1'b0) begin
      n_bad++; $display("FAIL cpu_rd_ctrl got stall=%b mw=%b exp 0/0", bus.cpu_stall, bus.MemWrite);
    end
    tick();
    set_cpu(0, 0, 0, 0, 0);
  endtask

  task automatic test_dma_read();
    set_dma(1, 0, ST_WORD, 32'h10, 32'd0);
    #1;
    n_cmp++; if (bus.dma_gnt !== 1'b1) begin n_bad++; $display("FAIL dma_rd_gnt got=%b exp=1", bus.dma_gnt); end
    n_cmp++; if (bus.cpu_rdata !== 32'd0) begin n_bad++; $display("FAIL dma_rd_cpu_rdata got=%h exp=0", bus.cpu_rdata); end
    tick();
    set_dma(0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (bus.dma_rvalid !== 1'b1) begin n_bad++; $display("FAIL dma_rd_rvalid got=%b exp=1", bus.dma_rvalid); end
    n_cmp++; if (bus.dma_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL dma_rd_data got=%h exp=deadbeef", bus.dma_rdata); end
    n_cmp++; if (bus.owner !== DMA) begin n_bad++; $display("FAIL dma_rd_owner got=%0d exp=DMA", bus.owner); end
    tick();
    #1;
    n_cmp++; if (bus.dma_rvalid !== 1'b0) begin n_bad++; $display("FAIL dma_rd_pulse got=%b exp=0", bus.dma_rvalid); end
  endtask

  task automatic test_contention();
    bit exp_g;
    for (int c = 0; c < 6; c++) begin
      set_cpu(1, 0, ST_WORD, 32'h100 + 32'(4 * c), 32'd0);
      set_dma(1, 0, ST_WORD, 32'h20, 32'd0);
      #1;
      exp_g = FAIR && (c == 4);
      n_cmp++; if (bus.dma_gnt !== exp_g) begin n_bad++; $display("FAIL contend_gnt c=%0d got=%b exp=%b", c, bus.dma_gnt, exp_g); end
      n_cmp++; if (bus.cpu_stall !== exp_g) begin n_bad++; $display("FAIL contend_stall c=%0d got=%b exp=%b", c, bus.cpu_stall, exp_g); end
      n_cmp++; if (bus.Addr !== (exp_g ? 32'h20 : 32'h100 + 32'(4 * c))) begin
        n_bad++; $display("FAIL contend_addr c=%0d got=%h", c, bus.Addr);
      end
      tick();
    end
    set_cpu(0, 0, 0, 0, 0);
    set_dma(0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_illegal();
    logic [31:0] save;
    save = ref_mem[0];
    set_dma(1, 1, ST_BYTE, 32'h2000, 32'h55);
    #1;
    n_cmp++; if (bus.dma_gnt !== 1'b1 || bus.MemWrite !== 1'b0) begin
      n_bad++; $display("FAIL ill_dma_grant got gnt=%b mw=%b exp 1/0", bus.dma_gnt, bus.MemWrite);
    end
    tick();
    set_dma(0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL ill_dma_err got=%b exp=1", bus.err); end
    n_cmp++; if (dm_mem[0] !== save) begin n_bad++; $display("FAIL ill_dma_mem got=%h exp=%h", dm_mem[0], save); end
    tick();
    set_cpu(1, 1, ST_HALF, 32'h3, 32'h1234);
    #1;
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL ill_err_pulse got=%b exp=0", bus.err); end
    n_cmp++; if (bus.MemWrite !== 1'b0 || bus.cpu_stall !== 1'b0) begin
      n_bad++; $display("FAIL ill_cpu_ctrl got mw=%b stall=%b exp 0/0", bus.MemWrite, bus.cpu_stall);
    end
    tick();
    set_cpu(0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL ill_cpu_err got=%b exp=1", bus.err); end
    n_cmp++; if (dm_mem[0] !== save) begin n_bad++; $display("FAIL ill_cpu_mem got=%h exp=%h", dm_mem[0], save); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] prev;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) set_dma(1, 0, ST_WORD, 32'h40 + 32'(8 * k), 32'd0);
      else       set_dma(0, 0, 0, 0, 0);
      #1;
      if (k > 0) begin
        n_cmp++; if (bus.dma_rvalid !== 1'b1) begin n_bad++; $display("FAIL b2b_rvalid k=%0d got=%b exp=1", k, bus.dma_rvalid); end
        n_cmp++; if (bus.dma_rdata !== prev) begin n_bad++; $display("FAIL b2b_rdata k=%0d got=%h exp=%h", k, bus.dma_rdata, prev); end
      end
      prev = ref_mem[(32'h40 + 32'(8 * k)) >> 2];
      tick();
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 31)) * 4;
    if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
    if ($urandom_range(0, 15) == 0) a = a + 32'h2000;
    return a;
  endfunction

  function automatic logic [2:0] rand_type();
    return ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
  endfunction

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) < 7) set_cpu(1, 1'($urandom_range(0, 1)), rand_type(), rand_addr(), $urandom());
      else                          set_cpu(0, 0, 0, 0, 0);
      if (!bus.dma_req || win == 2) begin
        if ($urandom_range(0, 9) < 5) set_dma(1, 1'($urandom_range(0, 1)), rand_type(), rand_addr(), $urandom());
        else                          set_dma(0, 0, 0, 0, 0);
      end
      #1;
      eval_model();
      n_cmp++; if (bus.dma_gnt !== e_dgnt || bus.cpu_stall !== e_stall) begin
        n_bad++; $display("FAIL rnd_grant c=%0d got gnt=%b stall=%b exp gnt=%b stall=%b", c, bus.dma_gnt, bus.cpu_stall, e_dgnt, e_stall);
      end
      n_cmp++; if (bus.MemWrite !== e_mw || bus.StoreType !== e_type) begin
        n_bad++; $display("FAIL rnd_ctrl c=%0d got mw=%b type=%0d exp mw=%b type=%0d", c, bus.MemWrite, bus.StoreType, e_mw, e_type);
      end
      n_cmp++; if (bus.Addr !== e_addr || bus.DataW !== e_dw) begin
        n_bad++; $display("FAIL rnd_bus c=%0d got addr=%h dw=%h exp addr=%h dw=%h", c, bus.Addr, bus.DataW, e_addr, e_dw);
      end
      n_cmp++; if (bus.cpu_rdata !== e_cpu_rdata) begin
        n_bad++; $display("FAIL rnd_cpu_rdata c=%0d got=%h exp=%h", c, bus.cpu_rdata, e_cpu_rdata);
      end
      n_cmp++; if (bus.err !== exp_err || bus.dma_rvalid !== exp_rvalid || bus.owner !== exp_owner) begin
        n_bad++; $display("FAIL rnd_regs c=%0d got err=%b rv=%b own=%0d exp err=%b rv=%b own=%0d",
                          c, bus.err, bus.dma_rvalid, bus.owner, exp_err, exp_rvalid, exp_owner);
      end
      if (exp_rvalid) begin
        n_cmp++; if (bus.dma_rdata !== exp_rdata) begin
          n_bad++; $display("FAIL rnd_dma_rdata c=%0d got=%h exp=%h", c, bus.dma_rdata, exp_rdata);
        end
      end
      tick();
    end
    set_cpu(0, 0, 0, 0, 0);
    set_dma(0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset_mid();
    set_dma(1, 0, 3'd3, 32'h40, 32'd0);
    tick();
    set_dma(1, 0, ST_WORD, 32'h44, 32'd0);
    #1;
    n_cmp++; if (bus.err !== 1'b1 || bus.dma_rvalid !== 1'b1 || bus.dma_gnt !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_pre got err=%b rv=%b gnt=%b exp 1/1/1", bus.err, bus.dma_rvalid, bus.dma_gnt);
    end
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.err !== 1'b0 || bus.dma_rvalid !== 1'b0 || bus.owner !== IDLE) begin
      n_bad++; $display("FAIL rstmid_async got err=%b rv=%b own=%0d exp 0/0/IDLE", bus.err, bus.dma_rvalid, bus.owner);
    end
    tick();
    set_dma(0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (bus.err !== 1'b0 || bus.dma_rvalid !== 1'b0 || bus.owner !== IDLE) begin
      n_bad++; $display("FAIL rstmid_hold got err=%b rv=%b own=%0d exp 0/0/IDLE", bus.err, bus.dma_rvalid, bus.owner);
    end
    reset = 1'b1;
    tick();
    #1;
    n_cmp++; if (bus.err !== 1'b0 || bus.dma_rvalid !== 1'b0 || bus.owner !== IDLE) begin
      n_bad++; $display("FAIL rstmid_release got err=%b rv=%b own=%0d exp 0/0/IDLE", bus.err, bus.dma_rvalid, bus.owner);
    end
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b0;
    n_cmp = 0;
    n_bad = 0;
    m_cnt = 0;
    win = 0;
    exp_err = 1'b0; exp_rvalid = 1'b0; exp_rdata = 32'd0; exp_owner = IDLE;
    for (int i = 0; i < 2048; i++) ref_mem[i] = init_word(i);
    set_cpu(0, 0, 0, 0, 0);
    set_dma(0, 0, 0, 0, 0);

    test_reset();
    test_cpu_only();
    test_dma_read();
    test_contention();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
